// File: rtl/counterd_pkg.sv
// Shared types for the counterd down-counter: FSM state encoding and the
// reload-mode encodings captured on a load edge.
package counterd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic PERIODIC = 1'b0;
  localparam logic ONESHOT  = 1'b1;

endpackage

// File: rtl/counterd.sv
// Loadable down-counter with periodic auto-reload or one-shot expiry.
// All outputs are registered; the FSM and the datapath share one clocked block.
module counterd
  import counterd_pkg::*;
#(
  parameter int N = 4
) (
  output logic [N-1:0] out,
  output logic         tc,
  output logic         done,
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         load,
  input  logic [N-1:0] din,
  input  logic         mode
);

  state_t       state;
  logic [N-1:0] reload;
  logic         mode_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      out    <= '0;
      reload <= '0;
      mode_q <= PERIODIC;
      tc     <= 1'b0;
      done   <= 1'b0;
    end else if (load) begin
      // Load wins over enable from every state and clears any expiry.
      out    <= din;
      reload <= din;
      mode_q <= mode;
      state  <= RUN;
      tc     <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out  <= '0;
          tc   <= 1'b0;
          done <= 1'b0;
        end
        RUN: begin
          tc <= 1'b0;
          if (enable) begin
            if (out != '0) begin
              out <= out - N'(1);
            end else if (mode_q == PERIODIC) begin
              // Terminal count: the zero cycle is part of the period (reload+1).
              out <= reload;
              tc  <= 1'b1;
            end else begin
              tc    <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          out  <= '0;
          tc   <= 1'b0;
          done <= 1'b1;
        end
        default: begin
          state <= IDLE;
          out   <= '0;
          tc    <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counterd.sv
// Directed bench for counterd (N=4): reset, periodic, one-shot, hold/priority
// and reload boundary cases with hand-computed expected values.
module tb_counterd;

  localparam int N = 4;

  logic [N-1:0] out;
  logic         tc;
  logic         done;
  logic         clk;
  logic         reset;
  logic         enable;
  logic         load;
  logic [N-1:0] din;
  logic         mode;

  int tests;
  int fails;

  counterd #(.N(N)) dut (
    .out    (out),
    .tc     (tc),
    .done   (done),
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .load   (load),
    .din    (din),
    .mode   (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [N-1:0] e_out, input logic e_tc,
                      input logic e_done);
    chk({tag, ".out"}, 32'(out), 32'(e_out));
    chk({tag, ".tc"}, 32'(tc), 32'(e_tc));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
  endtask

  logic [N-1:0] per_out [5] = '{4'd2, 4'd1, 4'd0, 4'd3, 4'd2};
  logic         per_tc  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [N-1:0] os_out  [5] = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
  logic         os_tc   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic         os_done [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    int tc_count;
    tests  = 0;
    fails  = 0;
    reset  = 1'b0;
    enable = 1'b0;
    load   = 1'b0;
    din    = '0;
    mode   = 1'b0;

    #3;
    chk3("reset_state", 4'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;

    // IDLE ignores enable until the first load.
    enable = 1'b1;
    tick();
    tick();
    chk3("idle_enable", 4'd0, 1'b0, 1'b0);

    // Periodic reload 3: 2,1,0,3(tc),2.
    enable = 1'b0; load = 1'b1; din = 4'd3; mode = 1'b0;
    tick();
    load = 1'b0;
    chk3("per_load", 4'd3, 1'b0, 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk3($sformatf("per_step%0d", i), per_out[i], per_tc[i], 1'b0);
    end

    // One-shot 2: 1,0,0(tc,done),0,0.
    enable = 1'b0; load = 1'b1; din = 4'd2; mode = 1'b1;
    tick();
    load = 1'b0;
    chk3("os_load", 4'd2, 1'b0, 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk3($sformatf("os_step%0d", i), os_out[i], os_tc[i], os_done[i]);
    end
    load = 1'b1; din = 4'd4; mode = 1'b0;
    tick();
    load = 1'b0;
    chk3("os_reload", 4'd4, 1'b0, 1'b0);

    // Hold at 6 with enable low, then load beats enable.
    enable = 1'b0; load = 1'b1; din = 4'd6; mode = 1'b0;
    tick();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk3($sformatf("hold%0d", i), 4'd6, 1'b0, 1'b0);
    end
    load = 1'b1; din = 4'd9; enable = 1'b1;
    tick();
    load = 1'b0;
    chk3("load_priority", 4'd9, 1'b0, 1'b0);
    tick();
    chk3("after_priority", 4'd8, 1'b0, 1'b0);

    // Count down to 5, then assert reset between clock edges.
    tick();
    tick();
    tick();
    chk3("pre_reset", 4'd5, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk3("async_reset", 4'd0, 1'b0, 1'b0);
    #1;
    reset = 1'b1;
    tick();
    tick();
    chk3("post_reset_idle", 4'd0, 1'b0, 1'b0);

    // Reset mid-DONE discards the expiry.
    enable = 1'b0; load = 1'b1; din = 4'd0; mode = 1'b1;
    tick();
    load = 1'b0; enable = 1'b1;
    tick();
    chk3("os0_expire", 4'd0, 1'b1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk3("reset_done", 4'd0, 1'b0, 1'b0);
    #1;
    reset = 1'b1;
    tick();
    chk3("done_reset_idle", 4'd0, 1'b0, 1'b0);

    // Periodic reload 0: tc every enabled cycle.
    enable = 1'b0; load = 1'b1; din = 4'd0; mode = 1'b0;
    tick();
    load = 1'b0;
    chk3("per0_load", 4'd0, 1'b0, 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk3($sformatf("per0_step%0d", i), 4'd0, 1'b1, 1'b0);
    end
    enable = 1'b0;
    tick();
    chk3("per0_hold", 4'd0, 1'b0, 1'b0);

    // Periodic reload 15: 16-cycle period.
    load = 1'b1; din = 4'd15; mode = 1'b0;
    tick();
    load = 1'b0;
    chk3("per15_load", 4'd15, 1'b0, 1'b0);
    enable = 1'b1;
    tc_count = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (tc) tc_count++;
      if (i < 15) chk($sformatf("per15_out%0d", i), 32'(out), 32'(14 - i));
      else        chk("per15_wrap", 32'(out), 32'd15);
    end
    chk("per15_tc_last", 32'(tc), 32'd1);
    chk("per15_tc_count", 32'(tc_count), 32'd1);
    tick();
    chk3("per15_next", 4'd14, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
